// File: rtl/rv32_mod_instruction_fetch.sv
// rv32_mod_instruction_fetch: instruction fetch front end for the rv32imc core.
// Fetches 32-bit words over a req/gnt/rvalid port and presents one instruction
// at a time with its PC over valid/ready. Redirects flush and restart fetch.
// Optional feature macro: RV32_FETCH_COMPRESSED_EN enables RVC parcel
// realignment (parcel buffer and straddle holding register). Without it every
// fetch is word aligned and any non-32-bit encoding is reported as a fault.
module rv32_mod_instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {S_REQ, S_WAIT, S_OUT, S_DRAIN, S_FAULT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        flt_q, flt_d;
    logic        hs;
    logic        outstanding;
    logic [31:0] fetch_addr;
    logic        unused_rpc;

`ifdef RV32_FETCH_COMPRESSED_EN
    logic [15:0] pbuf_q, pbuf_d;
    logic        pbuf_v_q, pbuf_v_d;
    logic [15:0] lo_q, lo_d;
    logic        lo_v_q, lo_v_d;

    // A pending low half means the next word completes a straddling instruction.
    assign fetch_addr = {pc_q[31:2], 2'b00} + (lo_v_q ? 32'd4 : 32'd0);
`else
    assign fetch_addr = {pc_q[31:2], 2'b00};
`endif

    assign unused_rpc  = redirect_pc[0];
    assign hs          = vld_q & instr_ready;
    // Request is masked while reset is held so the bus sees idle during reset.
    assign imem_req    = (state_q == S_REQ) & ~rst;
    assign imem_addr   = imem_req ? fetch_addr : 32'd0;
    assign instr_valid = vld_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_fault = flt_q;

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= {RESET_PC[31:1], 1'b0};
            vld_q    <= 1'b0;
            instr_q  <= 32'd0;
            ipc_q    <= 32'd0;
            flt_q    <= 1'b0;
`ifdef RV32_FETCH_COMPRESSED_EN
            pbuf_q   <= 16'd0;
            pbuf_v_q <= 1'b0;
            lo_q     <= 16'd0;
            lo_v_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            vld_q    <= vld_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            flt_q    <= flt_d;
`ifdef RV32_FETCH_COMPRESSED_EN
            pbuf_q   <= pbuf_d;
            pbuf_v_q <= pbuf_v_d;
            lo_q     <= lo_d;
            lo_v_q   <= lo_v_d;
`endif
        end
    end

    // Next state: fetch sequencing, realignment, output handshake, redirect.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        vld_d       = vld_q;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
        flt_d       = flt_q;
        outstanding = 1'b0;
`ifdef RV32_FETCH_COMPRESSED_EN
        pbuf_d      = pbuf_q;
        pbuf_v_d    = pbuf_v_q;
        lo_d        = lo_q;
        lo_v_d      = lo_v_q;
`endif
        case (state_q)
            S_REQ: if (imem_gnt) state_d = S_WAIT;
            S_WAIT: if (imem_rvalid) begin
                // Defaults for an emitted instruction; branches override.
                vld_d   = 1'b1;
                ipc_d   = pc_q;
                flt_d   = 1'b0;
                state_d = S_OUT;
                if (imem_err) begin
                    instr_d = 32'd0;
                    flt_d   = 1'b1;
                    state_d = S_FAULT;
`ifdef RV32_FETCH_COMPRESSED_EN
                    pbuf_v_d = 1'b0;
                    lo_v_d   = 1'b0;
                end else if (lo_v_q) begin
                    instr_d = {imem_rdata[15:0], lo_q};
                    lo_v_d  = 1'b0;
                end else if (!pc_q[1]) begin
                    if (imem_rdata[1:0] != 2'b11) begin
                        instr_d  = {16'd0, imem_rdata[15:0]};
                        pbuf_d   = imem_rdata[31:16];
                        pbuf_v_d = 1'b1;
                    end else begin
                        instr_d = imem_rdata;
                    end
                end else if (imem_rdata[17:16] != 2'b11) begin
                    instr_d = {16'd0, imem_rdata[31:16]};
                end else begin
                    // Upper half starts a 32-bit instruction: fetch the next word.
                    lo_d    = imem_rdata[31:16];
                    lo_v_d  = 1'b1;
                    vld_d   = 1'b0;
                    state_d = S_REQ;
                end
`else
                end else if (imem_rdata[1:0] != 2'b11) begin
                    instr_d = 32'd0;
                    flt_d   = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    instr_d = imem_rdata;
                end
`endif
            end
            S_OUT: if (hs) begin
                vld_d   = 1'b0;
                state_d = S_REQ;
`ifdef RV32_FETCH_COMPRESSED_EN
                pc_d = pc_q + ((instr_q[1:0] != 2'b11) ? 32'd2 : 32'd4);
                if (pbuf_v_q) begin
                    pbuf_v_d = 1'b0;
                    if (pbuf_q[1:0] != 2'b11) begin
                        // Buffered compressed parcel: no memory access needed.
                        vld_d   = 1'b1;
                        instr_d = {16'd0, pbuf_q};
                        ipc_d   = pc_d;
                        flt_d   = 1'b0;
                        state_d = S_OUT;
                    end else begin
                        lo_d   = pbuf_q;
                        lo_v_d = 1'b1;
                    end
                end
`else
                pc_d = pc_q + 32'd4;
`endif
            end
            S_DRAIN: if (imem_rvalid) state_d = S_REQ;
            S_FAULT: if (hs) vld_d = 1'b0;
            default: state_d = S_REQ;
        endcase

        // Redirect overrides everything above; a same-cycle response is dropped.
        if (redirect_valid) begin
            outstanding = ((state_q == S_WAIT) && !imem_rvalid) ||
                          ((state_q == S_REQ) && imem_gnt) ||
                          ((state_q == S_DRAIN) && !imem_rvalid);
            pc_d    = {redirect_pc[31:1], 1'b0};
            vld_d   = 1'b0;
            flt_d   = 1'b0;
            state_d = outstanding ? S_DRAIN : S_REQ;
`ifdef RV32_FETCH_COMPRESSED_EN
            pbuf_v_d = 1'b0;
            lo_v_d   = 1'b0;
`else
            // Halfword-aligned target cannot be fetched without RVC support.
            if (redirect_pc[1]) begin
                vld_d   = 1'b1;
                flt_d   = 1'b1;
                instr_d = 32'd0;
                ipc_d   = pc_d;
                state_d = S_FAULT;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rv32_mod_instruction_fetch.sv
// Bench for rv32_mod_instruction_fetch: vector table, directed corner cases
// and a randomized run against an instruction-stream reference model.
module tb_rv32_mod_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_err = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    rv32_mod_instruction_fetch #(.RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_fault(instr_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: 1 KB image, word index = addr[9:2], per-word bus error flag.
    logic [31:0] mem [256];
    bit          merr [256];

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference model: walks the instruction stream from the architectural PC.
    logic [31:0] mpc;
    bit          dead;

    task automatic model_next(output logic [31:0] ei, output logic [31:0] ep, output logic ef);
        logic [15:0] lo, hi;
        logic [31:0] nx;
        ep = mpc;
`ifdef RV32_FETCH_COMPRESSED_EN
        lo = half(mpc);
        if (lo[1:0] != 2'b11) begin
            ei  = {16'h0, lo};
            ef  = merr[mpc[9:2]];
            mpc = mpc + 2;
        end else begin
            nx  = mpc + 2;
            hi  = half(nx);
            ei  = {hi, lo};
            ef  = merr[mpc[9:2]] || merr[nx[9:2]];
            mpc = mpc + 4;
        end
`else
        ei  = mem[mpc[9:2]];
        ef  = mpc[1] || merr[mpc[9:2]] || (ei[1:0] != 2'b11);
        mpc = mpc + 4;
`endif
        if (ef) begin
            ei   = 32'd0;
            dead = 1'b1;
        end
    endtask

    typedef struct { logic [31:0] ins; logic [31:0] pc; logic flt; } hs_t;
    hs_t hq[$];
    int  last_hs = 0;
    int  hs_total = 0;

    // Previous-cycle observations for protocol checks.
    logic        p_valid, p_ready, p_redir, p_req, p_gnt, p_rvalid, p_hs, p_flt;
    logic [31:0] p_addr, p_instr, p_pc;

    task automatic clear_prev();
        p_valid = 0; p_ready = 0; p_redir = 0; p_req = 0; p_gnt = 0;
        p_rvalid = 0; p_hs = 0; p_flt = 0; p_addr = 0; p_instr = 0; p_pc = 0;
    endtask

    task automatic observe();
        logic [31:0] ei, ep;
        logic        ef;
        if (rst) begin
            clear_prev();
            return;
        end
        if (instr_valid && instr_ready) begin
            hq.push_back('{instr, instr_pc, instr_fault});
            hs_total++;
            last_hs = cyc;
            if (dead) begin
                checks++;
                errs++;
                $display("FAIL hs_after_fault: got pc %h expected no instruction", instr_pc);
            end else begin
                model_next(ei, ep, ef);
                chk("sb_instr", instr, ei);
                chk("sb_pc", instr_pc, ep);
                chk("sb_fault", 32'(instr_fault), 32'(ef));
            end
        end
        if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 0);
        chk("no_overlap", 32'(instr_valid && imem_req), 0);
        if (p_req && !p_gnt && !p_redir) begin
            chk("req_hold", 32'(imem_req), 1);
            chk("req_addr_hold", imem_addr, p_addr);
        end
        if (p_valid && !p_ready && !p_redir) begin
            chk("out_hold_v", 32'(instr_valid), 1);
            chk("out_hold_i", instr, p_instr);
            chk("out_hold_pc", instr_pc, p_pc);
        end
        if (instr_valid && !p_valid && !p_redir) chk("valid_after_rvalid", 32'(p_rvalid), 1);
        if (p_hs && !p_redir && !p_flt && !instr_valid) chk("req_after_hs", 32'(imem_req), 1);
        if (redirect_valid) begin
            mpc     = {redirect_pc[31:1], 1'b0};
            dead    = 1'b0;
            last_hs = cyc;
        end
        if (dead) last_hs = cyc;
        p_valid = instr_valid; p_ready = instr_ready; p_redir = redirect_valid;
        p_req = imem_req; p_gnt = imem_gnt; p_rvalid = imem_rvalid;
        p_hs = instr_valid && instr_ready; p_flt = instr_fault;
        p_addr = imem_addr; p_instr = instr; p_pc = instr_pc;
    endtask

    // Memory responder state.
    bit          granted = 0;
    bit          pend = 0;
    int          pcnt = 0;
    logic [31:0] gaddr = 0;
    logic [31:0] paddr = 0;
    int          lat_lo = 0;
    int          lat_hi = 2;
    bit          rnd_gnt = 0;

    // One clock: check at current inputs, then advance to the next negedge.
    task automatic tick();
        #1;
        observe();
        granted = !rst && imem_req && imem_gnt;
        gaddr   = imem_addr;
        @(negedge clk);
        cyc++;
        imem_rvalid = 0;
        imem_err    = 0;
        imem_rdata  = 0;
        if (rst) begin
            pend = 0;
        end else begin
            if (granted) begin
                pend  = 1;
                pcnt  = $urandom_range(lat_hi, lat_lo);
                paddr = gaddr;
            end
            if (pend) begin
                if (pcnt == 0) begin
                    imem_rvalid = 1;
                    imem_rdata  = mem[paddr[9:2]];
                    imem_err    = merr[paddr[9:2]];
                    pend        = 0;
                end else begin
                    pcnt--;
                end
            end
        end
        imem_gnt = rnd_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'd0;
            merr[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1; instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
        repeat (3) tick();
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_fault", 32'(instr_fault), 0);
        rst = 0; mpc = 32'h100; dead = 0; hq.delete(); last_hs = cyc;
        #1;
        chk("first_req", 32'(imem_req), 1);
        chk("first_addr", imem_addr, 32'h100);
    endtask

    function automatic logic [15:0] rhalf();
        logic [15:0] h;
        h = 16'($urandom);
`ifdef RV32_FETCH_COMPRESSED_EN
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else h[1:0] = 2'($urandom_range(0, 2));
`else
        if ($urandom_range(0, 15) != 0) h[1:0] = 2'b11;
`endif
        return h;
    endfunction

    typedef struct {
        logic [31:0] w100, w104; logic e104; int n;
        logic [31:0] i0, p0; logic f0;
        logic [31:0] i1, p1; logic f1;
        logic idle;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #1000000;
        errs++;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        logic ok_a, ok_b;
        logic [31:0] s_i, s_p;

        clear_prev();
        clear_mem();
        // {w100, w104, err104, n, instr0, pc0, f0, instr1, pc1, f1, idle}
        tbl[0] = '{32'h00500093, 32'h00a00113, 1'b0, 2, 32'h00500093, 32'h100, 1'b0, 32'h00a00113, 32'h104, 1'b0, 1'b0};
        tbl[3] = '{32'h00500093, 32'h00a00113, 1'b1, 2, 32'h00500093, 32'h100, 1'b0, 32'h0, 32'h104, 1'b1, 1'b1};
`ifdef RV32_FETCH_COMPRESSED_EN
        tbl[1] = '{32'h45054501, 32'h0, 1'b0, 2, 32'h4501, 32'h100, 1'b0, 32'h4505, 32'h102, 1'b0, 1'b0};
        tbl[2] = '{32'h00934501, 32'h12340050, 1'b0, 2, 32'h4501, 32'h100, 1'b0, 32'h00500093, 32'h102, 1'b0, 1'b0};
        tbl[4] = '{32'h00934501, 32'h12340050, 1'b1, 2, 32'h4501, 32'h100, 1'b0, 32'h0, 32'h102, 1'b1, 1'b1};
        tbl[5] = '{32'h00014501, 32'h0, 1'b0, 2, 32'h4501, 32'h100, 1'b0, 32'h0001, 32'h102, 1'b0, 1'b0};
`else
        tbl[1] = '{32'h45054501, 32'h0, 1'b0, 1, 32'h0, 32'h100, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[2] = '{32'h00934501, 32'h12340050, 1'b0, 1, 32'h0, 32'h100, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[4] = '{32'h00934501, 32'h12340050, 1'b1, 1, 32'h0, 32'h100, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[5] = '{32'h00014501, 32'h0, 1'b0, 1, 32'h0, 32'h100, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1};
`endif

        // Vector table.
        for (int i = 0; i < 6; i++) begin
            clear_mem();
            mem[64] = tbl[i].w100;
            mem[65] = tbl[i].w104;
            merr[65] = tbl[i].e104;
            do_reset();
            instr_ready = 1;
            b = 0;
            while (hq.size() < tbl[i].n && b < 80) begin tick(); b++; end
            if (hq.size() < tbl[i].n) begin
                checks++; errs++;
                $display("FAIL vec%0d_timeout: got %0d instructions expected %0d", i, hq.size(), tbl[i].n);
            end else begin
                chk($sformatf("vec%0d_i0", i), hq[0].ins, tbl[i].i0);
                chk($sformatf("vec%0d_p0", i), hq[0].pc, tbl[i].p0);
                chk($sformatf("vec%0d_f0", i), 32'(hq[0].flt), 32'(tbl[i].f0));
                if (tbl[i].n > 1) begin
                    chk($sformatf("vec%0d_i1", i), hq[1].ins, tbl[i].i1);
                    chk($sformatf("vec%0d_p1", i), hq[1].pc, tbl[i].p1);
                    chk($sformatf("vec%0d_f1", i), 32'(hq[1].flt), 32'(tbl[i].f1));
                end
            end
            if (tbl[i].idle) begin
                ok_a = 1;
                repeat (5) begin tick(); if (imem_req) ok_a = 0; end
                chk($sformatf("vec%0d_fault_idle", i), 32'(ok_a), 1);
                redirect_valid = 1; redirect_pc = 32'h100;
                tick();
                redirect_valid = 0;
                #1;
                chk($sformatf("vec%0d_redir_req", i), 32'(imem_req), 1);
                chk($sformatf("vec%0d_redir_addr", i), imem_addr, 32'h100);
            end
        end

        // Back-pressure: output stable, no request, then 0x100 -> 0x104.
        clear_mem();
        mem[64] = 32'h00500093;
        mem[65] = 32'h00a00113;
        do_reset();
        b = 0;
        while (!instr_valid && b < 20) begin tick(); b++; end
        chk("stall_valid", 32'(instr_valid), 1);
        s_i = instr; s_p = instr_pc;
        ok_a = 1; ok_b = 1;
        repeat (5) begin
            tick();
            if (!instr_valid || instr !== s_i || instr_pc !== s_p) ok_a = 0;
            if (imem_req) ok_b = 0;
        end
        chk("stall_stable", 32'(ok_a), 1);
        chk("stall_noreq", 32'(ok_b), 1);
        instr_ready = 1;
        b = 0;
        while (hq.size() < 2 && b < 40) begin tick(); b++; end
        if (hq.size() < 2) begin
            checks++; errs++;
            $display("FAIL stall_seq_timeout: got %0d instructions expected 2", hq.size());
        end else begin
            chk("stall_seq_p0", hq[0].pc, 32'h100);
            chk("stall_seq_p1", hq[1].pc, 32'h104);
            chk("stall_seq_i1", hq[1].ins, 32'h00a00113);
        end

        // Redirect while a response is outstanding, consumer never ready.
        clear_mem();
        mem[64]  = 32'h00500093;
        mem[128] = 32'h00200213;
        lat_lo = 3; lat_hi = 3;
        do_reset();
        tick();
        redirect_valid = 1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 0;
        b = 0;
        while (!imem_req && b < 20) begin tick(); b++; end
        chk("drain_req", 32'(imem_req), 1);
        chk("drain_addr", imem_addr, 32'h200);
        b = 0;
        while (!instr_valid && b < 20) begin tick(); b++; end
        chk("drain_pc", instr_pc, 32'h200);
        chk("drain_instr", instr, 32'h00200213);
        instr_ready = 1;
        tick();
        lat_lo = 0; lat_hi = 3;

        // Randomized run against the reference model.
        for (int i = 0; i < 256; i++) begin
            mem[i]  = {rhalf(), rhalf()};
            merr[i] = ($urandom_range(0, 39) == 0);
        end
        do_reset();
        rnd_gnt = 1;
        hs_total = 0;
        for (int k = 0; k < 4000; k++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 59) == 0);
`ifdef RV32_FETCH_COMPRESSED_EN
            redirect_pc = $urandom & 32'h0000_03fe;
`else
            redirect_pc = $urandom & 32'h0000_03fc;
`endif
            tick();
            if (!dead && cyc - last_hs > 300) begin
                checks++; errs++;
                $display("FAIL rand_stuck: got no instruction for %0d cycles expected progress", cyc - last_hs);
                last_hs = cyc;
            end
        end
        redirect_valid = 0;
        chk("rand_progress", 32'(hs_total > 200), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
